// File: rtl/sysu_scan_ctrl.sv
// Dynamic-scan controller for an 8-digit multiplexed 7-segment display.
// Drives the 74LS138 address/enables and the shared active-low segment bus.
module sysu_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16,
  parameter int NDIG  = 8
) (
  input  logic        CP,
  input  logic        CR_n,
  input  logic        EN,
  input  logic [31:0] DATA,
  input  logic [7:0]  DP,
  input  logic [7:0]  BLANK_MASK,
  output logic        A0,
  output logic        A1,
  output logic        A2,
  output logic        E1,
  output logic        E2_n,
  output logic        E3_n,
  output logic [6:0]  SEG_n,
  output logic        DP_n,
  output logic        FRAME
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK);
  localparam logic [2:0]    DIG_LAST = 3'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, BLANKING, SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    digit_q, digit_d;
  logic [3:0]    nib_q, nib_d;
  logic          dp_q, dp_d;
  logic          mask_q, mask_d;
  logic [2:0]    addr_q, addr_d;
  logic          e1_q, e1_d;
  logic          e2n_q, e2n_d;
  logic          e3n_q, e3n_d;
  logic [6:0]    seg_q, seg_d;
  logic          dpn_q, dpn_d;
  logic          frame_q, frame_d;
  logic          load;
  logic          lit;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    nib_d   = nib_q;
    dp_d    = dp_q;
    mask_d  = mask_q;
    frame_d = 1'b0;
    load    = 1'b0;

    if (!EN) begin
      state_d = IDLE;
      cnt_d   = '0;
      digit_d = '0;
    end else begin
      if (state_q == IDLE) begin
        cnt_d   = '0;
        digit_d = '0;
        load    = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        digit_d = (digit_q == DIG_LAST) ? 3'd0 : digit_q + 3'd1;
        load    = 1'b1;
        frame_d = (digit_d == 3'd0);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      state_d = (cnt_d < CNT_SHOW) ? BLANKING : SHOW;
    end

    // Per-digit inputs are captured only at slot start so mid-slot edits never tear a glyph.
    if (load) begin
      nib_d  = DATA[{digit_d, 2'b00} +: 4];
      dp_d   = DP[digit_d];
      mask_d = BLANK_MASK[digit_d];
    end

    lit    = (state_d == SHOW) && !mask_d;
    addr_d = digit_d;
    e1_d   = lit;
    e2n_d  = !lit;
    e3n_d  = !lit;
    seg_d  = lit ? glyph(nib_d) : 7'h7F;
    dpn_d  = lit ? !dp_d : 1'b1;
  end

  always_ff @(posedge CP) begin
    if (!CR_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      digit_q <= '0;
      nib_q   <= '0;
      dp_q    <= 1'b0;
      mask_q  <= 1'b0;
      addr_q  <= '0;
      e1_q    <= 1'b0;
      e2n_q   <= 1'b1;
      e3n_q   <= 1'b1;
      seg_q   <= 7'h7F;
      dpn_q   <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      nib_q   <= nib_d;
      dp_q    <= dp_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      e1_q    <= e1_d;
      e2n_q   <= e2n_d;
      e3n_q   <= e3n_d;
      seg_q   <= seg_d;
      dpn_q   <= dpn_d;
      frame_q <= frame_d;
    end
  end

  assign A0    = addr_q[0];
  assign A1    = addr_q[1];
  assign A2    = addr_q[2];
  assign E1    = e1_q;
  assign E2_n  = e2n_q;
  assign E3_n  = e3n_q;
  assign SEG_n = seg_q;
  assign DP_n  = dpn_q;
  assign FRAME = frame_q;

endmodule
